// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: the input channel (raw immediate plus
// mode and rotate) and the registered output channel.
interface imm_extend_pipe_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned ROT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [ROT_W-1:0] in_rot;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;

    // master: upstream producer / downstream consumer side
    modport master (
        output in_valid, in_imm, in_mode, in_rot, out_ready,
        input  in_ready, out_valid, out_imm
    );

    // slave: the extension unit
    modport slave (
        input  in_valid, in_imm, in_mode, in_rot, out_ready,
        output in_ready, out_valid, out_imm
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign extend, rotate-right by 2*rot, or
// sign extend shifted left by 2, behind a single valid/ready output register.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned ROT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    imm_extend_pipe_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_ZEXT   = 2'b00,
        MODE_SEXT   = 2'b01,
        MODE_ROT    = 2'b10,
        MODE_SEXTSH = 2'b11
    } mode_e;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_imm_q, out_imm_d;

    logic             accept;
    logic [OUT_W-1:0] zext, sext, rot_res, ext_res;
    logic [2*OUT_W-1:0] rot_dbl;
    mode_e            mode;

    assign zext = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
    assign sext = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};

    // Rotate right by shifting a doubled copy; the low half is the rotation.
    assign rot_dbl = {zext, zext} >> {bus.in_rot, 1'b0};
    assign rot_res = rot_dbl[OUT_W-1:0];

    assign mode = mode_e'(bus.in_mode);

    always_comb begin
        ext_res = zext;
        unique case (mode)
            MODE_ZEXT:   ext_res = zext;
            MODE_SEXT:   ext_res = sext;
            MODE_ROT:    ext_res = rot_res;
            MODE_SEXTSH: ext_res = sext << 2;
            default:     ext_res = zext;
        endcase
    end

    assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = ext_res;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vector table, backpressure and reset
// sequences, then random traffic against a cycle-level reference model.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(8), .OUT_W(32), .ROT_W(4)) bus ();

    imm_extend_pipe #(.IN_W(8), .OUT_W(32), .ROT_W(4)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // reference model state
    logic        m_valid;
    logic [31:0] m_imm;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  imm;
        logic [3:0]  rot;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_f(logic [1:0] m, logic [7:0] i, logic [3:0] r);
        int          sv;
        logic [31:0] z;
        logic [31:0] res;
        sv  = (i >= 8'd128) ? int'(i) - 256 : int'(i);
        z   = {24'd0, i};
        res = z;
        case (m)
            2'd0: res = z;
            2'd1: res = 32'(sv);
            2'd2: begin
                for (int k = 0; k < 2 * int'(r); k++) res = {res[0], res[31:1]};
            end
            default: res = 32'(sv * 4);
        endcase
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready, advance the model, check registered outputs.
    task automatic tick();
        logic m_ready;
        #1;
        m_ready = !rst && (!m_valid || bus.out_ready);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
        if (rst) begin
            m_valid = 1'b0;
            m_imm   = '0;
        end else if (bus.in_valid && m_ready) begin
            m_valid = 1'b1;
            m_imm   = ref_f(bus.in_mode, bus.in_imm, bus.in_rot);
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("out_imm", bus.out_imm, m_imm);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] i,
                         input logic [3:0] r, input logic ordy);
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_imm    = i;
        bus.in_rot    = r;
        bus.out_ready = ordy;
    endtask

    vec_t vecs[11];

    initial begin
        m_valid = 1'b0;
        m_imm   = '0;
        rst     = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        tick();
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_imm", bus.out_imm, 32'd0);
        rst = 1'b0;

        vecs[0]  = '{2'b00, 8'hA5, 4'd0,  32'h000000A5};
        vecs[1]  = '{2'b01, 8'hA5, 4'd0,  32'hFFFFFFA5};
        vecs[2]  = '{2'b01, 8'h5A, 4'd0,  32'h0000005A};
        vecs[3]  = '{2'b10, 8'hFF, 4'd0,  32'h000000FF};
        vecs[4]  = '{2'b10, 8'hFF, 4'd1,  32'hC000003F};
        vecs[5]  = '{2'b10, 8'hFF, 4'd4,  32'hFF000000};
        vecs[6]  = '{2'b10, 8'hFF, 4'd15, 32'h000003FC};
        vecs[7]  = '{2'b11, 8'h80, 4'd0,  32'hFFFFFE00};
        vecs[8]  = '{2'b11, 8'h01, 4'd0,  32'h00000004};
        vecs[9]  = '{2'b00, 8'h80, 4'd7,  32'h00000080};
        vecs[10] = '{2'b11, 8'h7F, 4'd3,  32'h000001FC};

        // back-to-back vectors, one result per cycle
        for (int n = 0; n < 11; n++) begin
            drive(1'b1, vecs[n].mode, vecs[n].imm, vecs[n].rot, 1'b1);
            tick();
            chk("vec_valid", {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("vec%0d", n), bus.out_imm, vecs[n].exp);
        end
        drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b1);
        tick();
        chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // backpressure
        drive(1'b1, 2'b00, 8'h11, 4'd0, 1'b1);
        tick();
        drive(1'b1, 2'b00, 8'h22, 4'd0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            chk("stall_imm", bus.out_imm, 32'h00000011);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("release_imm", bus.out_imm, 32'h00000022);
        drive(1'b0, 2'd0, 8'h00, 4'd0, 1'b1);
        tick();

        // reset while stalled with a pending result
        drive(1'b1, 2'b01, 8'h99, 4'd0, 1'b1);
        tick();
        drive(1'b1, 2'b00, 8'h33, 4'd0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_imm", bus.out_imm, 32'd0);
        rst = 1'b0;
        drive(1'b1, 2'b01, 8'h5A, 4'd0, 1'b1);
        tick();
        chk("post_rst_imm", bus.out_imm, 32'h0000005A);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) != 0));
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
